product_accumulator: RTL



---
 rtl/product_accumulator.sv | 114 +++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// Sums a job of len signed products into an ACC_W accumulator (saturating or wrapping); result on valid/ready.
// prod_ready is high only in ACCUM; out_valid rises the cycle after the final product and holds until out_ready.
module product_accumulator #(
   parameter int PROD_W   = 64,
   parameter int ACC_W    = 72,
   parameter int LEN_W    = 16,
   parameter int SATURATE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [PROD_W-1:0] prod,
   input  logic              prod_valid,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t             state;
   state_t             state_nxt;
   logic [LEN_W-1:0]   remaining;
   logic [ACC_W-1:0]   acc;
   logic               ovf;

   logic               xfer;
   logic [ACC_W:0]     sum_ext;
   logic               add_ovf;
   logic [ACC_W-1:0]   acc_nxt;

   assign xfer = (state == ACCUM) && prod_valid;

   // One guard bit above ACC_W: overflow shows as disagreement of the top two bits.
   assign sum_ext = {acc[ACC_W-1], acc}
                  + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
   assign add_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

   always_comb begin
      acc_nxt = sum_ext[ACC_W-1:0];
      if (add_ovf && (SATURATE != 0)) begin
         acc_nxt = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (len != '0) ? ACCUM : DONE;
            end
         end
         ACCUM: begin
            if (xfer && (remaining == LEN_W'(1))) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         remaining <= '0;
         ovf       <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  remaining <= len;
                  acc       <= '0;
                  ovf       <= 1'b0;
               end
            end
            ACCUM: begin
               // The counter only moves while nonzero, so it can never wrap.
               if (xfer && (remaining != '0)) begin
                  acc       <= acc_nxt;
                  remaining <= remaining - LEN_W'(1);
                  ovf       <= ovf | add_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   assign prod_ready = (state == ACCUM);
   assign out_valid  = (state == DONE);
   assign busy       = (state != IDLE);
   assign acc_out    = acc;
   assign overflow   = ovf;

endmodule
